// File: rtl/spi_sample_pkg.sv
// Shared definitions for the SPI sample receiver: nibble bit positions and FSM state types.
package spi_sample_pkg;

    localparam int NIB_I1 = 3;
    localparam int NIB_I0 = 2;
    localparam int NIB_Q1 = 1;
    localparam int NIB_Q0 = 0;

    typedef enum logic {
        DES_IDLE,
        DES_SHIFT
    } des_state_e;

    typedef enum logic {
        UNP_EMPTY,
        UNP_EMIT
    } unp_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; the caller only asserts push_i when a slot is free
// (or a pop happens in the same cycle), so every push_i is a committed write.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/spi_sample_rx.sv
// SPI sample receiver: synchronises SCK/SS/MOSI, deserialises words into a FIFO and
// unpacks each word into 2-bit I/Q sample pairs on a valid/ready stream.
module spi_sample_rx
    import spi_sample_pkg::*;
#(
    parameter int WORD_BITS   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        SPI_SCK,
    input  logic        SPI_SS,
    input  logic        SPI_MOSI,
    input  logic        CLR,
    input  logic        SAMPLE_READY,
    output logic        SAMPLE_VALID,
    output logic        SAMPLE_I1,
    output logic        SAMPLE_I0,
    output logic        SAMPLE_Q1,
    output logic        SAMPLE_Q0,
    output logic        OVERFLOW,
    output logic        FRAME_ERR,
    output logic [15:0] WORD_COUNT
);

    localparam int NIBBLES = WORD_BITS / 4;
    localparam int CNT_W   = $clog2(WORD_BITS);
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int SET_W   = $clog2(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
    logic                   sck_prev_q;
    logic                   sck_s, ss_s, mosi_s, sck_rise;
    logic [SET_W-1:0]       settle_q;
    logic                   settled, armed_q;

    des_state_e             des_state_q, des_state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [WORD_BITS-1:0]   shift_q, shift_d;
    logic [WORD_BITS-1:0]   push_word_q, push_word_d;
    logic                   push_q, push_d;
    logic                   frame_err_q, frame_err_d;

    logic                   overflow_q, overflow_d;
    logic [15:0]            word_count_q, word_count_d;

    unp_state_e             unp_state_q, unp_state_d;
    logic [IDX_W-1:0]       nib_idx_q, nib_idx_d;

    logic                   fifo_wr, fifo_pop, fifo_full, fifo_empty, drop;
    logic [WORD_BITS-1:0]   fifo_rdata;
    logic [LVL_W-1:0]       fifo_level;
    logic                   handshake;
    logic [3:0]             nibble;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign ss_s     = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s && !sck_prev_q;
    // The synchroniser resets SS to "high"; only trust it once real samples have flushed through.
    assign settled  = (settle_q == SET_W'(SYNC_STAGES));

    always_comb begin
        des_state_d = des_state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        push_word_d = push_word_q;
        push_d      = 1'b0;
        frame_err_d = 1'b0;
        case (des_state_q)
            DES_IDLE: begin
                bit_cnt_d = '0;
                if (armed_q && !ss_s) des_state_d = DES_SHIFT;
            end
            DES_SHIFT: begin
                if (ss_s) begin
                    des_state_d = DES_IDLE;
                    bit_cnt_d   = '0;
                    frame_err_d = (bit_cnt_q != '0);
                end else if (sck_rise) begin
                    shift_d = {shift_q[WORD_BITS-2:0], mosi_s};
                    if (bit_cnt_q == CNT_W'(WORD_BITS - 1)) begin
                        bit_cnt_d   = '0;
                        push_d      = 1'b1;
                        push_word_d = {shift_q[WORD_BITS-2:0], mosi_s};
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: des_state_d = DES_IDLE;
        endcase
    end

    assign handshake = (unp_state_q == UNP_EMIT) && SAMPLE_READY;
    assign fifo_pop  = handshake && (nib_idx_q == '0);
    assign fifo_wr   = push_q && (!fifo_full || fifo_pop);
    assign drop      = push_q && fifo_full && !fifo_pop;

    always_comb begin
        overflow_d   = overflow_q;
        word_count_d = word_count_q + {15'd0, fifo_wr};
        if (CLR) begin
            overflow_d   = 1'b0;
            word_count_d = '0;
        end
        if (drop) overflow_d = 1'b1;
    end

    // The unpacker reads the FIFO head in place and retires the word on its last nibble.
    always_comb begin
        unp_state_d = unp_state_q;
        nib_idx_d   = nib_idx_q;
        case (unp_state_q)
            UNP_EMPTY: begin
                if (fifo_wr) begin
                    unp_state_d = UNP_EMIT;
                    nib_idx_d   = IDX_W'(NIBBLES - 1);
                end
            end
            UNP_EMIT: begin
                if (handshake) begin
                    if (nib_idx_q == '0) begin
                        nib_idx_d   = IDX_W'(NIBBLES - 1);
                        unp_state_d = (fifo_level > LVL_W'(1) || fifo_wr) ? UNP_EMIT : UNP_EMPTY;
                    end else begin
                        nib_idx_d = nib_idx_q - IDX_W'(1);
                    end
                end
            end
            default: unp_state_d = UNP_EMPTY;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sck_sync_q   <= '0;
            ss_sync_q    <= '1;
            mosi_sync_q  <= '0;
            sck_prev_q   <= 1'b0;
            settle_q     <= '0;
            armed_q      <= 1'b0;
            des_state_q  <= DES_IDLE;
            bit_cnt_q    <= '0;
            push_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
            word_count_q <= '0;
            unp_state_q  <= UNP_EMPTY;
            nib_idx_q    <= '0;
        end else begin
            sck_sync_q   <= {sck_sync_q[SYNC_STAGES-2:0], SPI_SCK};
            ss_sync_q    <= {ss_sync_q[SYNC_STAGES-2:0], SPI_SS};
            mosi_sync_q  <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
            sck_prev_q   <= sck_s;
            if (!settled) settle_q <= settle_q + SET_W'(1);
            armed_q      <= armed_q | (settled & ss_s);
            des_state_q  <= des_state_d;
            bit_cnt_q    <= bit_cnt_d;
            push_q       <= push_d;
            frame_err_q  <= frame_err_d;
            overflow_q   <= overflow_d;
            word_count_q <= word_count_d;
            unp_state_q  <= unp_state_d;
            nib_idx_q    <= nib_idx_d;
        end
    end

    always_ff @(posedge CLK) begin
        shift_q     <= shift_d;
        push_word_q <= push_word_d;
    end

    sync_fifo #(
        .WIDTH (WORD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RESET_N),
        .push_i  (fifo_wr),
        .pop_i   (fifo_pop),
        .wdata_i (push_word_q),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign nibble       = fifo_rdata[{nib_idx_q, 2'b00} +: 4];
    assign SAMPLE_VALID = (unp_state_q == UNP_EMIT) && !fifo_empty;
    assign SAMPLE_I1    = SAMPLE_VALID & nibble[NIB_I1];
    assign SAMPLE_I0    = SAMPLE_VALID & nibble[NIB_I0];
    assign SAMPLE_Q1    = SAMPLE_VALID & nibble[NIB_Q1];
    assign SAMPLE_Q0    = SAMPLE_VALID & nibble[NIB_Q0];
    assign OVERFLOW     = overflow_q;
    assign FRAME_ERR    = frame_err_q;
    assign WORD_COUNT   = word_count_q;

endmodule

// File: tb/tb_spi_sample_rx.sv
// Randomised bench for spi_sample_rx: drives SPI frames and scores the sample stream
// against a queue of expected nibbles derived from the words sent.
module tb_spi_sample_rx;

    localparam int SYNC = 2;

    logic        CLK = 1'b0;
    logic        RESET_N, SPI_SCK, SPI_SS, SPI_MOSI, CLR, SAMPLE_READY;
    logic        SAMPLE_VALID, SAMPLE_I1, SAMPLE_I0, SAMPLE_Q1, SAMPLE_Q0;
    logic        OVERFLOW, FRAME_ERR;
    logic [15:0] WORD_COUNT;

    int          n_checks = 0;
    int          n_errs   = 0;
    int          cyc      = 0;
    int          fe_cnt   = 0;
    int          rise_cyc = 0;
    int          ready_mode = 1;
    int          hp = 4;
    int          exp_wc = 0;
    bit          lat_en = 1'b0;
    logic        prev_valid = 1'b0;
    logic [3:0]  nib;
    logic [3:0]  exp_q[$];
    int          hs_cyc[$];

    spi_sample_rx #(
        .WORD_BITS   (16),
        .SYNC_STAGES (SYNC),
        .FIFO_DEPTH  (4)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .SPI_SCK      (SPI_SCK),
        .SPI_SS       (SPI_SS),
        .SPI_MOSI     (SPI_MOSI),
        .CLR          (CLR),
        .SAMPLE_READY (SAMPLE_READY),
        .SAMPLE_VALID (SAMPLE_VALID),
        .SAMPLE_I1    (SAMPLE_I1),
        .SAMPLE_I0    (SAMPLE_I0),
        .SAMPLE_Q1    (SAMPLE_Q1),
        .SAMPLE_Q0    (SAMPLE_Q0),
        .OVERFLOW     (OVERFLOW),
        .FRAME_ERR    (FRAME_ERR),
        .WORD_COUNT   (WORD_COUNT)
    );

    initial forever #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // READY pattern changes just after the rising edge so it is stable when sampled.
    initial begin
        SAMPLE_READY = 1'b0;
        forever begin
            @(posedge CLK);
            #2;
            case (ready_mode)
                0:       SAMPLE_READY = 1'b0;
                1:       SAMPLE_READY = 1'b1;
                2:       SAMPLE_READY = ~SAMPLE_READY;
                default: SAMPLE_READY = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Scoreboard: every valid cycle must show the oldest outstanding nibble.
    initial forever begin
        @(negedge CLK);
        if (FRAME_ERR) fe_cnt++;
        if (SAMPLE_VALID) begin
            nib = {SAMPLE_I1, SAMPLE_I0, SAMPLE_Q1, SAMPLE_Q0};
            if (lat_en && !prev_valid) begin
                check("latency", cyc - rise_cyc, SYNC + 2);
                lat_en = 1'b0;
            end
            if (exp_q.size() == 0) begin
                check("spurious_valid", SAMPLE_VALID, 0);
            end else begin
                check("sample", nib, exp_q[0]);
                if (SAMPLE_READY) begin
                    void'(exp_q.pop_front());
                    hs_cyc.push_back(cyc);
                end
            end
        end
        prev_valid = SAMPLE_VALID;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_bits(input logic [31:0] v, input int nb);
        for (int i = nb - 1; i >= 0; i--) begin
            SPI_MOSI = v[i];
            wait_n(hp);
            SPI_SCK  = 1'b1;
            rise_cyc = cyc;
            wait_n(hp);
            SPI_SCK  = 1'b0;
        end
    endtask

    task automatic send_word(input logic [15:0] w, input bit kept);
        if (kept) begin
            for (int k = 3; k >= 0; k--) exp_q.push_back(w[k*4 +: 4]);
            exp_wc++;
        end
        send_bits({16'd0, w}, 16);
    endtask

    task automatic ss_low();
        SPI_SS = 1'b0;
        wait_n(4);
    endtask

    task automatic ss_high();
        wait_n(4);
        SPI_SS = 1'b1;
        wait_n(8);
    endtask

    task automatic pulse_clr();
        @(negedge CLK);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        exp_wc = 0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge CLK);
        end
        check(tag, exp_q.size(), 0);
        wait_n(3);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, SAMPLE_VALID, 0);
        check({tag, "_samples"}, {SAMPLE_I1, SAMPLE_I0, SAMPLE_Q1, SAMPLE_Q0}, 0);
        check({tag, "_ovf"}, OVERFLOW, 0);
        check({tag, "_ferr"}, FRAME_ERR, 0);
        check({tag, "_wc"}, WORD_COUNT, 0);
    endtask

    initial begin
        int fe0;
        int wc0;
        int nbits;
        RESET_N = 1'b0; SPI_SCK = 1'b0; SPI_SS = 1'b1; SPI_MOSI = 1'b0; CLR = 1'b0;
        wait_n(3);
        check_all_zero("reset");
        RESET_N = 1'b1;
        wait_n(5);

        // Single word, always ready: four consecutive samples.
        hs_cyc.delete();
        lat_en = 1'b1;
        ss_low();
        send_word(16'hA5C3, 1'b1);
        ss_high();
        wait_drain("t1_drain");
        check("t1_hs_count", hs_cyc.size(), 4);
        if (hs_cyc.size() == 4) check("t1_consecutive", hs_cyc[3] - hs_cyc[0], 3);
        check("t1_wc", WORD_COUNT, exp_wc);

        // Back-to-back words inside one frame with READY toggling.
        ready_mode = 2;
        ss_low();
        send_word(16'h1234, 1'b1);
        send_word(16'hFFFF, 1'b1);
        ss_high();
        wait_drain("t2_drain");
        check("t2_wc", WORD_COUNT, exp_wc);
        check("t2_idle", SAMPLE_VALID, 0);

        // Overflow: READY held low, six words into a four-deep buffer.
        ready_mode = 1;
        pulse_clr();
        check("clr_wc", WORD_COUNT, 0);
        ready_mode = 0;
        ss_low();
        for (int i = 0; i < 4; i++) send_word(16'($urandom), 1'b1);
        wait_n(6);
        check("ovf_before", OVERFLOW, 0);
        check("ovf_wc4", WORD_COUNT, 4);
        send_word(16'($urandom), 1'b0);
        wait_n(6);
        check("ovf_set", OVERFLOW, 1);
        check("ovf_wc_hold", WORD_COUNT, 4);
        send_word(16'($urandom), 1'b0);
        ss_high();
        check("ovf_sticky", OVERFLOW, 1);
        ready_mode = 1;
        wait_drain("t3_drain");
        check("t3_wc", WORD_COUNT, 4);
        pulse_clr();
        check("clr_ovf", OVERFLOW, 0);
        check("clr_wc2", WORD_COUNT, 0);

        // Frame error after 9 bits, then a clean word.
        fe0 = fe_cnt;
        ss_low();
        send_bits($urandom, 9);
        ss_high();
        check("fe_once", fe_cnt - fe0, 1);
        check("fe_no_push", WORD_COUNT, exp_wc);
        lat_en = 1'b1;
        ss_low();
        send_word(16'h0F0F, 1'b1);
        ss_high();
        wait_drain("t4_drain");
        check("t4_wc", WORD_COUNT, exp_wc);

        // SCK activity while deselected must be ignored.
        wc0 = exp_wc;
        fe0 = fe_cnt;
        for (int i = 0; i < 20; i++) begin
            SPI_MOSI = 1'($urandom);
            wait_n(hp); SPI_SCK = 1'b1;
            wait_n(hp); SPI_SCK = 1'b0;
        end
        wait_n(6);
        check("ssh_wc", WORD_COUNT, wc0);
        check("ssh_valid", SAMPLE_VALID, 0);
        check("ssh_fe", fe_cnt - fe0, 0);

        // Reset mid-word; the rest of that frame must not produce a word.
        ss_low();
        send_bits($urandom, 7);
        RESET_N = 1'b0;
        wait_n(2);
        check_all_zero("rst_mid");
        exp_wc = 0;
        RESET_N = 1'b1;
        fe0 = fe_cnt;
        send_bits($urandom, 9);
        wait_n(6);
        check("rst_no_word", WORD_COUNT, 0);
        check("rst_no_valid", SAMPLE_VALID, 0);
        ss_high();
        check("rst_no_fe", fe_cnt - fe0, 0);
        lat_en = 1'b1;
        ss_low();
        send_word(16'h8001, 1'b1);
        ss_high();
        wait_drain("t6_drain");
        check("t6_wc", WORD_COUNT, exp_wc);

        // Random frames, random READY, occasional truncated frames.
        ready_mode = 3;
        for (int f = 0; f < 12; f++) begin
            hp = 4 + int'($urandom_range(0, 2));
            ss_low();
            for (int w = 0; w < int'($urandom_range(1, 3)); w++) send_word(16'($urandom), 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                fe0 = fe_cnt;
                nbits = int'($urandom_range(1, 15));
                send_bits($urandom, nbits);
                ss_high();
                check("rnd_fe", fe_cnt - fe0, 1);
            end else begin
                ss_high();
            end
        end
        wait_drain("rnd_drain");
        check("rnd_wc", WORD_COUNT, exp_wc);
        check("final_ovf", OVERFLOW, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
